// File: rtl/dmem_arbiter_if.sv
// Requester/memory bundle for the data-memory arbiter.
// slave: arbiter side; master: requesters plus memory model.
interface dmem_arbiter_if;
  logic        req0_i;
  logic        we0_i;
  logic [31:0] addr0_i;
  logic [31:0] data0_i;
  logic        ack0_o;
  logic        err0_o;
  logic [31:0] data0_o;
  logic        req1_i;
  logic        we1_i;
  logic [31:0] addr1_i;
  logic [31:0] data1_i;
  logic        ack1_o;
  logic        err1_o;
  logic [31:0] data1_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic [31:0] addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  modport slave (
    input  req0_i, we0_i, addr0_i, data0_i,
    input  req1_i, we1_i, addr1_i, data1_i,
    input  mem_rdata_i,
    output ack0_o, err0_o, data0_o,
    output ack1_o, err1_o, data1_o,
    output MemRead_o, MemWrite_o,
    output addr_o, mem_wdata_o, busy_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, data0_i,
    output req1_i, we1_i, addr1_i, data1_i,
    output mem_rdata_i,
    input  ack0_o, err0_o, data0_o,
    input  ack1_o, err1_o, data1_o,
    input  MemRead_o, MemWrite_o,
    input  addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the data memory.
// Ports: clk_i, rst_i (sync, active-high), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
  parameter int MEM_BYTES  = 32,
  parameter int ACC_CYCLES = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYCLES - 1);
  localparam logic [31:0] MAX_A = 32'(MEM_BYTES - 4);

  state_t        state_q;
  logic          last_grant_q;
  logic          port_q;
  logic          we_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          err0_q;
  logic          err1_q;
  logic [31:0]   data0_q;
  logic [31:0]   data1_q;

  logic          req_any;
  logic          grant_d;
  logic          we_d;
  logic [31:0]   addr_d;
  logic [31:0]   wdata_d;
  logic          err_d;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    req_any = bus.req0_i | bus.req1_i;
    grant_d = bus.req1_i;
    if (bus.req0_i && bus.req1_i)
      grant_d = ~last_grant_q;
    we_d    = grant_d ? bus.we1_i   : bus.we0_i;
    addr_d  = grant_d ? bus.addr1_i : bus.addr0_i;
    wdata_d = grant_d ? bus.data1_i : bus.data0_i;
    err_d   = (addr_d[1:0] != 2'b00) || (addr_d > MAX_A);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            port_q       <= grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= grant_d;
            if (err_d) begin
              // Bad address: answer straight away.
              state_q <= RESP;
              ack0_q  <= ~grant_d;
              ack1_q  <= grant_d;
              err0_q  <= ~grant_d;
              err1_q  <= grant_d;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= CNT_LOAD;
              rd_q    <= ~we_d;
              wr_q    <= we_d;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            if (!we_q && !port_q)
              data0_q <= bus.mem_rdata_i;
            if (!we_q && port_q)
              data1_q <= bus.mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0_o      = ack0_q;
  assign bus.ack1_o      = ack1_q;
  assign bus.err0_o      = err0_q & err_q;
  assign bus.err1_o      = err1_q & err_q;
  assign bus.data0_o     = data0_q;
  assign bus.data1_o     = data1_q;
  assign bus.MemRead_o   = rd_q;
  assign bus.MemWrite_o  = wr_q;
  assign bus.addr_o      = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Covers reset, read/write, fairness, errors, mid-op reset, long access.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  dmem_arbiter_if b ();
  dmem_arbiter_if b3 ();

  dmem_arbiter #(.MEM_BYTES(32), .ACC_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(b.slave)
  );

  dmem_arbiter #(.MEM_BYTES(32), .ACC_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(b3.slave)
  );

  logic [31:0] mem [8];
  assign b.mem_rdata_i  = mem[b.addr_o[4:2]];
  assign b3.mem_rdata_i = 32'h0;

  localparam logic [31:0] A0 = 32'hA0A0_0001;
  localparam logic [31:0] A1 = 32'hA1A1_0002;

  task automatic drive_idle();
    b.req0_i = 0; b.we0_i = 0; b.addr0_i = 0; b.data0_i = 0;
    b.req1_i = 0; b.we1_i = 0; b.addr1_i = 0; b.data1_i = 0;
    b3.req0_i = 0; b3.we0_i = 0; b3.addr0_i = 0; b3.data0_i = 0;
    b3.req1_i = 0; b3.we1_i = 0; b3.addr1_i = 0; b3.data1_i = 0;
  endtask

  // Issue one request on dut and observe it until ack (bounded).
  // Leaves the arbiter back in IDLE.
  task automatic access(
    input  bit          p,
    input  bit          we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output int          rdc,
    output int          wrc,
    output bit          e,
    output bit          oth,
    output bit          stab
  );
    bit got;
    got = 0; lat = -1; rdc = 0; wrc = 0;
    e = 0; oth = 0; stab = 1;
    if (p) begin
      b.req1_i = 1; b.we1_i = we; b.addr1_i = a; b.data1_i = d;
    end else begin
      b.req0_i = 1; b.we0_i = we; b.addr0_i = a; b.data0_i = d;
    end
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (b.MemRead_o) rdc++;
      if (b.MemWrite_o) begin
        wrc++;
        mem[b.addr_o[4:2]] = b.mem_wdata_o;
      end
      if ((b.MemRead_o || b.MemWrite_o) && b.addr_o !== a)
        stab = 0;
      if (b.MemWrite_o && b.mem_wdata_o !== d)
        stab = 0;
      if ((p ? b.ack1_o : b.ack0_o) === 1'b1) begin
        got = 1;
        lat = i;
        e = p ? b.err1_o : b.err0_o;
        oth = p ? b.ack0_o : b.ack1_o;
      end
    end
    b.req0_i = 0;
    b.req1_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({b.ack0_o, b.ack1_o, b.err0_o, b.err1_o,
         b.MemRead_o, b.MemWrite_o, b.busy_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0",
        {b.ack0_o, b.ack1_o, b.err0_o, b.err1_o,
         b.MemRead_o, b.MemWrite_o, b.busy_o});
    end
    checks++;
    if ({b.addr_o, b.mem_wdata_o, b.data0_o, b.data1_o} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data addr=%h wd=%h d0=%h d1=%h want=0",
        b.addr_o, b.mem_wdata_o, b.data0_o, b.data1_o);
    end
    checks++;
    if ({b3.busy_o, b3.MemWrite_o, b3.addr_o, b3.data0_o} !== 66'b0) begin
      failures++;
      $display("FAIL reset_dut3 got nonzero outputs");
    end
    rst = 0;
  endtask

  task automatic test_read();
    int lat, rdc, wrc;
    bit e, oth, st;
    b.req0_i = 1; b.we0_i = 0; b.addr0_i = 32'd8;
    @(posedge clk); #1;
    checks++;
    if (b.MemRead_o !== 1 || b.MemWrite_o !== 0 || b.addr_o !== 32'd8
        || b.ack0_o !== 0) begin
      failures++;
      $display("FAIL read_access rd=%b wr=%b addr=%h ack=%b want 1 0 8 0",
        b.MemRead_o, b.MemWrite_o, b.addr_o, b.ack0_o);
    end
    @(posedge clk); #1;
    b.req0_i = 0;
    checks++;
    if (b.ack0_o !== 1 || b.err0_o !== 0 || b.MemRead_o !== 0
        || b.ack1_o !== 0) begin
      failures++;
      $display("FAIL read_ack ack=%b err=%b rd=%b ack1=%b want 1 0 0 0",
        b.ack0_o, b.err0_o, b.MemRead_o, b.ack1_o);
    end
    checks++;
    if (b.data0_o !== 32'h1122_3344) begin
      failures++;
      $display("FAIL read_data got=%h want=11223344", b.data0_o);
    end
    @(posedge clk); #1;
    checks++;
    if (b.ack0_o !== 0 || b.busy_o !== 0) begin
      failures++;
      $display("FAIL read_idle ack=%b busy=%b want 0 0", b.ack0_o, b.busy_o);
    end
    // Same access again through the observer: latency and single pulse.
    access(0, 0, 32'd8, 0, lat, rdc, wrc, e, oth, st);
    checks++;
    if (lat != 2 || rdc != 1 || wrc != 0 || e !== 0) begin
      failures++;
      $display("FAIL read_lat lat=%0d rd=%0d wr=%0d err=%b want 2 1 0 0",
        lat, rdc, wrc, e);
    end
  endtask

  task automatic test_write_then_read();
    int lat, rdc, wrc;
    bit e, oth, st;
    access(1, 1, 32'd28, 32'hDEAD_BEEF, lat, rdc, wrc, e, oth, st);
    checks++;
    if (lat != 2 || wrc != 1 || rdc != 0 || e !== 0 || oth !== 0
        || st !== 1) begin
      failures++;
      $display("FAIL wr28 lat=%0d wr=%0d rd=%0d err=%b oth=%b st=%b",
        lat, wrc, rdc, e, oth, st);
    end
    checks++;
    if (b.data1_o !== 32'h0) begin
      failures++;
      $display("FAIL wr_keeps_data1 got=%h want=0", b.data1_o);
    end
    checks++;
    if (mem[7] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_mem got=%h want=deadbeef", mem[7]);
    end
    access(0, 0, 32'd28, 0, lat, rdc, wrc, e, oth, st);
    checks++;
    if (lat != 2 || rdc != 1 || e !== 0
        || b.data0_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd28 lat=%0d rd=%0d err=%b data=%h want 2 1 0 deadbeef",
        lat, rdc, e, b.data0_o);
    end
  endtask

  task automatic test_errors();
    int lat, rdc, wrc;
    bit e, oth, st;
    logic [31:0] bad [3];
    bad[0] = 32'd6; bad[1] = 32'd30; bad[2] = 32'd29;
    for (int k = 0; k < 3; k++) begin
      access(0, 0, bad[k], 0, lat, rdc, wrc, e, oth, st);
      checks++;
      if (lat != 1 || rdc != 0 || wrc != 0 || e !== 1 || oth !== 0
          || b.data0_o !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL err0_a%0d lat=%0d rd=%0d wr=%0d err=%b d0=%h",
          bad[k], lat, rdc, wrc, e, b.data0_o);
      end
    end
    access(1, 1, 32'd32, 32'h5555_5555, lat, rdc, wrc, e, oth, st);
    checks++;
    if (lat != 1 || wrc != 0 || e !== 1 || oth !== 0
        || mem[0] !== A0) begin
      failures++;
      $display("FAIL err1_a32 lat=%0d wr=%0d err=%b oth=%b m0=%h",
        lat, wrc, e, oth, mem[0]);
    end
  endtask

  task automatic test_fairness();
    int n, both;
    bit g [4];
    int t [4];
    n = 0; both = 0;
    do_reset();
    rst = 0;
    b.req0_i = 1; b.we0_i = 0; b.addr0_i = 32'd0;
    b.req1_i = 1; b.we1_i = 0; b.addr1_i = 32'd4;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (b.ack0_o && b.ack1_o) both++;
      if ((b.ack0_o || b.ack1_o) && n < 4) begin
        g[n] = b.ack1_o;
        t[n] = i;
        n++;
      end
    end
    b.req0_i = 0; b.req1_i = 0;
    checks++;
    if (n != 4 || both != 0) begin
      failures++;
      $display("FAIL rr_count acks=%0d both=%0d want 4 0", n, both);
    end else begin
      checks++;
      if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin
        failures++;
        $display("FAIL rr_order got=%b%b%b%b want=0101",
          g[0], g[1], g[2], g[3]);
      end
      checks++;
      if (t[0] != 2 || t[1] != 5 || t[2] != 8 || t[3] != 11) begin
        failures++;
        $display("FAIL rr_spacing got=%0d,%0d,%0d,%0d want 2,5,8,11",
          t[0], t[1], t[2], t[3]);
      end
    end
    checks++;
    if (b.data0_o !== A0 || b.data1_o !== A1) begin
      failures++;
      $display("FAIL rr_data d0=%h d1=%h want %h %h",
        b.data0_o, b.data1_o, A0, A1);
    end
    @(posedge clk); #1;
    checks++;
    if (b.busy_o !== 0) begin
      failures++;
      $display("FAIL rr_idle busy=%b want 0", b.busy_o);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    lat = -1;
    b.req1_i = 1; b.we1_i = 0; b.addr1_i = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (b.MemRead_o !== 1 || b.busy_o !== 1) begin
      failures++;
      $display("FAIL mid_access rd=%b busy=%b want 1 1",
        b.MemRead_o, b.busy_o);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (b.busy_o !== 0 || b.MemRead_o !== 0 || b.ack1_o !== 0
        || b.data1_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset busy=%b rd=%b ack1=%b d1=%h want 0 0 0 0",
        b.busy_o, b.MemRead_o, b.ack1_o, b.data1_o);
    end
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (b.ack1_o === 1'b1) lat = i;
    end
    b.req1_i = 0;
    checks++;
    if (lat != 2 || b.data1_o !== A0 || b.err1_o !== 0) begin
      failures++;
      $display("FAIL mid_retry lat=%0d d1=%h err=%b want 2 %h 0",
        lat, b.data1_o, b.err1_o, A0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_long_access();
    int lat, wrc, rdc;
    bit st;
    lat = -1; wrc = 0; rdc = 0; st = 1;
    b3.req0_i = 1; b3.we0_i = 1;
    b3.addr0_i = 32'd12; b3.data0_i = 32'hCAFE_F00D;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (b3.MemRead_o) rdc++;
      if (b3.MemWrite_o) begin
        wrc++;
        if (b3.addr_o !== 32'd12 || b3.mem_wdata_o !== 32'hCAFE_F00D)
          st = 0;
      end
      if (b3.ack0_o === 1'b1) lat = i;
    end
    b3.req0_i = 0;
    checks++;
    if (wrc != 3 || rdc != 0 || st !== 1) begin
      failures++;
      $display("FAIL long_wr wr=%0d rd=%0d stable=%b want 3 0 1",
        wrc, rdc, st);
    end
    checks++;
    if (lat != 4 || b3.err0_o !== 0 || b3.data0_o !== 32'h0) begin
      failures++;
      $display("FAIL long_ack lat=%0d err=%b d0=%h want 4 0 0",
        lat, b3.err0_o, b3.data0_o);
    end
    @(posedge clk); #1;
    checks++;
    if (b3.busy_o !== 0 || b3.MemWrite_o !== 0) begin
      failures++;
      $display("FAIL long_idle busy=%b wr=%b want 0 0",
        b3.busy_o, b3.MemWrite_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[0] = A0;
    mem[1] = A1;
    mem[2] = 32'h1122_3344;
    test_reset();
    test_read();
    test_write_then_read();
    test_errors();
    test_fairness();
    test_reset_midop();
    test_long_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
